// File: rtl/registers_file.sv
// General-purpose register file: two combinational read ports, one clocked write port.
// Register 0 is hardwired to zero. Reset is synchronous.
module registers_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    // Address 0 is decoded directly so it reads zero even before the first reset.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != '0) read_data1 = regs[read_reg1];
        if (read_reg2 != '0) read_data2 = regs[read_reg2];
    end

endmodule

// File: tb/tb_registers_file.sv
// Directed bench for registers_file: reset, write/read, gating, register 0,
// dual-port read-during-write, back-to-back writes and reset priority.
module tb_registers_file;

    logic        clk;
    logic        rst_n;
    logic        write_enable;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks;
    int errors;

    registers_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_enable(write_enable),
        .read_reg1(read_reg1),
        .read_reg2(read_reg2),
        .write_reg(write_reg),
        .write_data(write_data),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present a write between edges, take one rising edge, then drop enable.
    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        write_enable = 1'b1;
        write_reg    = addr;
        write_data   = data;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_reg1 = a1;
        read_reg2 = a2;
        #1;
    endtask

    task automatic idle_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b1;
        write_enable = 1'b0;
        read_reg1    = '0;
        read_reg2    = '0;
        write_reg    = '0;
        write_data   = '0;
        #2;

        rd(5'd0, 5'd0);
        check("pre_reset_r0_p1", read_data1, 32'h0);
        check("pre_reset_r0_p2", read_data2, 32'h0);

        // Reset clear
        wr(5'd7, 32'hDEADBEEF);
        rd(5'd7, 5'd7);
        check("pre_reset_r7", read_data1, 32'hDEADBEEF);
        @(negedge clk);
        rst_n = 1'b0;
        idle_edge();
        rst_n = 1'b1;
        rd(5'd7, 5'd7);
        check("reset_r7_p1", read_data1, 32'h0);
        check("reset_r7_p2", read_data2, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check("reset_sweep_p1", read_data1, 32'h0);
            check("reset_sweep_p2", read_data2, 32'h0);
        end

        // Basic write/read, value holds over idle edges
        wr(5'd20, 32'd10);
        rd(5'd20, 5'd0);
        check("basic_r20", read_data1, 32'd10);
        for (int i = 0; i < 3; i++) begin
            idle_edge();
            check("basic_hold_r20", read_data1, 32'd10);
        end

        // Write enable gating
        @(negedge clk);
        write_enable = 1'b0;
        write_reg    = 5'd5;
        write_data   = 32'h12345678;
        idle_edge();
        rd(5'd5, 5'd5);
        check("gated_r5", read_data1, 32'h0);

        // Register 0 hardwired
        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        check("r0_write_p1", read_data1, 32'h0);
        check("r0_write_p2", read_data2, 32'h0);

        // Dual-port and read-during-write
        wr(5'd3, 32'hA5A5A5A5);
        wr(5'd31, 32'h5A5A5A5A);
        @(negedge clk);
        rd(5'd3, 5'd31);
        check("dual_r3", read_data1, 32'hA5A5A5A5);
        check("dual_r31", read_data2, 32'h5A5A5A5A);
        write_enable = 1'b1;
        write_reg    = 5'd3;
        write_data   = 32'h11111111;
        read_reg2    = 5'd3;
        #1;
        check("rdw_before_p1", read_data1, 32'hA5A5A5A5);
        check("rdw_before_p2", read_data2, 32'hA5A5A5A5);
        idle_edge();
        write_enable = 1'b0;
        check("rdw_after_p1", read_data1, 32'h11111111);
        check("rdw_after_p2", read_data2, 32'h11111111);
        rd(5'd31, 5'd20);
        check("dual_r31_kept", read_data1, 32'h5A5A5A5A);
        check("dual_r20_kept", read_data2, 32'd10);

        // Back-to-back writes to one address, one value per edge
        @(negedge clk);
        rd(5'd12, 5'd12);
        write_enable = 1'b1;
        write_reg    = 5'd12;
        write_data   = 32'h00000001;
        idle_edge();
        check("b2b_1", read_data1, 32'h00000001);
        write_data = 32'h00000002;
        idle_edge();
        check("b2b_2", read_data1, 32'h00000002);
        write_data = 32'h00000003;
        idle_edge();
        check("b2b_3", read_data2, 32'h00000003);
        write_enable = 1'b0;

        // Reset vs write priority, held reset ignores writes, writes resume after
        wr(5'd9, 32'h99999999);
        rd(5'd9, 5'd9);
        check("r9_before_reset", read_data1, 32'h99999999);
        @(negedge clk);
        rst_n        = 1'b0;
        write_enable = 1'b1;
        write_reg    = 5'd9;
        write_data   = 32'hCAFEF00D;
        idle_edge();
        check("rst_prio_r9", read_data1, 32'h0);
        idle_edge();
        idle_edge();
        check("rst_held_r9", read_data2, 32'h0);
        rd(5'd12, 5'd31);
        check("rst_held_r12", read_data1, 32'h0);
        check("rst_held_r31", read_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(5'd9, 5'd9);
        check("rst_release_before_edge", read_data1, 32'h0);
        idle_edge();
        write_enable = 1'b0;
        check("rst_release_write", read_data1, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
